buffer_in: RTL and testbench

- Input-side counterpart of the output row buffer. Accepts the narrow image stream one BAND_WIDTH beat at a time and steers each image row into lane FIFO (row mod BLK_WIDTH).
- Emits one BLK_WIDTH*BAND_WIDTH word holding the same column band of BLK_WIDTH consecutive rows.
- Sits between the memory-read stream and the block-processing kernel, which consumes BLK_WIDTH rows in parallel.

---
 rtl/buffer_pkg.sv | 27 ++
 rtl/buffer_lane_fifo.sv | 58 +++++
 rtl/buffer_in.sv | 173 +++++++++++++++++
 tb/tb_buffer_in.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared constants and helpers for the row buffers (buffer_in / buffer_out).
// Image geometry lives here; band and lane widths stay as module parameters.
package buffer_pkg;

   localparam int IM_WIDTH      = 800;
   localparam int IM_DATA_WIDTH = 8;
   localparam int ROW_CNT       = IM_WIDTH;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Bit width needed to hold an index 0..n-1, never less than one bit.
   function automatic int idx_width(input int n);
      return (clog2(n) > 0) ? clog2(n) : 1;
   endfunction

   // Beats per image row for a given band width and channel packing.
   function automatic int col_cnt(input int band_width, input int chn_cnt);
      return IM_WIDTH * IM_DATA_WIDTH * chn_cnt / band_width;
   endfunction

endpackage

// File: rtl/buffer_lane_fifo.sv
// First-word-fall-through lane FIFO: a word written in cycle N is visible on
// o_dout in cycle N+1. Write and read in the same cycle are both performed.
// rst and i_flush both empty the FIFO synchronously.
module buffer_lane_fifo import buffer_pkg::*; #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 512,
   localparam int PTR_W = idx_width(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];
   assign w_wr    = i_wr && !o_full;
   assign w_rd    = i_rd && !o_empty;

   // Pointer and occupancy tracking; flush has priority over traffic.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/buffer_in.sv
// Input row buffer: steers each image row into lane (row mod BLK_WIDTH) and
// emits one word holding the same column band of BLK_WIDTH consecutive rows.
// Optional macro BUFFER_IN_OUT_REG_EN adds a 2-entry registered skid stage on
// the output (one extra cycle of latency, full throughput kept).
//
// Handshakes: a beat/word moves only in a cycle where valid && ready are both
// high; ready never depends on valid, and valid once raised holds its data
// until taken. rst or i_done in the same cycle discards any transfer.
module buffer_in import buffer_pkg::*; #(
   parameter int BAND_WIDTH = 512,
   parameter int FIFO_DEPTH = 128,
   parameter int BLK_WIDTH  = 4,
   parameter int IM_CHN_CNT = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_done,
   input  logic [BAND_WIDTH-1:0]           i_im_data,
   input  logic                            i_im_vld,
   output logic                            o_im_rdy,
   output logic [BLK_WIDTH*BAND_WIDTH-1:0] o_im_data,
   output logic                            o_im_vld,
   input  logic                            i_im_rdy,
   output logic                            o_im_in_last,
   output logic                            o_blk_last
);

   localparam int COL_CNT     = col_cnt(BAND_WIDTH, IM_CHN_CNT);
   localparam int BLK_ROW_CNT = ROW_CNT / BLK_WIDTH;
   localparam int COL_W       = idx_width(COL_CNT);
   localparam int ROW_W       = idx_width(ROW_CNT);
   localparam int BROW_W      = idx_width(BLK_ROW_CNT);
   localparam int LANE_W      = idx_width(BLK_WIDTH);
   localparam int CNT_W       = idx_width(FIFO_DEPTH) + 1;
   localparam int OW          = BLK_WIDTH * BAND_WIDTH;

   logic [COL_W-1:0]      r_in_col;
   logic [ROW_W-1:0]      r_in_row;
   logic [COL_W-1:0]      r_out_col;
   logic [BROW_W-1:0]     r_out_brow;
   logic                  w_clr;
   logic [LANE_W-1:0]     w_lane_sel;
   logic                  w_in_xfer;
   logic                  w_pop;
   logic                  w_heads_vld;
   logic                  w_head_last;
   logic [BLK_WIDTH-1:0]  w_wr;
   logic [BLK_WIDTH-1:0]  w_full;
   logic [BLK_WIDTH-1:0]  w_empty;
   logic [BAND_WIDTH-1:0] w_head [BLK_WIDTH];
   logic [CNT_W-1:0]      w_unused_count [BLK_WIDTH];
   logic [OW-1:0]         w_head_word;

   assign w_clr        = rst || i_done;
   assign w_lane_sel   = r_in_row[LANE_W-1:0];
   assign o_im_rdy     = !w_full[w_lane_sel];
   assign w_in_xfer    = i_im_vld && o_im_rdy && !w_clr;
   assign w_heads_vld  = &(~w_empty);
   assign w_head_last  = w_heads_vld && (r_out_col == COL_W'(COL_CNT - 1)) &&
                         (r_out_brow == BROW_W'(BLK_ROW_CNT - 1));
   assign o_im_in_last = w_in_xfer && (r_in_col == COL_W'(COL_CNT - 1)) &&
                         (r_in_row == ROW_W'(ROW_CNT - 1));

   // Route the accepted beat to the lane owning the current row.
   always_comb begin
      w_wr = '0;
      for (int k = 0; k < BLK_WIDTH; k++) begin
         w_wr[k] = w_in_xfer && (w_lane_sel == LANE_W'(k));
      end
   end

   for (genvar k = 0; k < BLK_WIDTH; k++) begin : g_lane
      buffer_lane_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (BAND_WIDTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_flush (i_done),
         .i_wr    (w_wr[k]),
         .i_din   (i_im_data),
         .i_rd    (w_pop),
         .o_dout  (w_head[k]),
         .o_full  (w_full[k]),
         .o_empty (w_empty[k]),
         .o_count (w_unused_count[k])
      );
      assign w_head_word[k*BAND_WIDTH +: BAND_WIDTH] = w_head[k];
   end

   // Input position: column within row, row within frame.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_in_col <= '0;
         r_in_row <= '0;
      end else if (w_in_xfer) begin
         if (r_in_col == COL_W'(COL_CNT - 1)) begin
            r_in_col <= '0;
            r_in_row <= (r_in_row == ROW_W'(ROW_CNT - 1)) ? '0 : r_in_row + ROW_W'(1);
         end else begin
            r_in_col <= r_in_col + COL_W'(1);
         end
      end
   end

   // Output position of the word at the lane heads: column and block-row.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_out_col  <= '0;
         r_out_brow <= '0;
      end else if (w_pop) begin
         if (r_out_col == COL_W'(COL_CNT - 1)) begin
            r_out_col  <= '0;
            r_out_brow <= (r_out_brow == BROW_W'(BLK_ROW_CNT - 1)) ? '0 : r_out_brow + BROW_W'(1);
         end else begin
            r_out_col <= r_out_col + COL_W'(1);
         end
      end
   end

`ifdef BUFFER_IN_OUT_REG_EN
   logic          r_out_vld;
   logic          r_out_last;
   logic [OW-1:0] r_out_data;
   logic          r_sk_vld;
   logic          r_sk_last;
   logic [OW-1:0] r_sk_data;
   logic          w_out_take;

   // Heads are popped only while the skid slot is free, so at most two words
   // are ever in flight past the lanes.
   assign w_pop      = w_heads_vld && !r_sk_vld && !w_clr;
   assign w_out_take = !r_out_vld || i_im_rdy;
   assign o_im_vld   = r_out_vld;
   assign o_im_data  = r_out_data;
   assign o_blk_last = r_out_last;

   // Output register refills from the skid first, then from the lane heads;
   // a popped word lands in the skid when the output is stalled.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
         r_out_data <= '0;
         r_sk_vld   <= 1'b0;
         r_sk_last  <= 1'b0;
         r_sk_data  <= '0;
      end else if (w_out_take) begin
         if (r_sk_vld) begin
            r_out_vld  <= 1'b1;
            r_out_last <= r_sk_last;
            r_out_data <= r_sk_data;
            r_sk_vld   <= 1'b0;
            r_sk_last  <= 1'b0;
         end else begin
            r_out_vld  <= w_pop;
            r_out_last <= w_pop && w_head_last;
            r_out_data <= w_head_word;
         end
      end else if (w_pop) begin
         r_sk_vld  <= 1'b1;
         r_sk_last <= w_head_last;
         r_sk_data <= w_head_word;
      end
   end
`else
   assign w_pop      = w_heads_vld && i_im_rdy && !w_clr;
   assign o_im_vld   = w_heads_vld;
   assign o_im_data  = w_head_word;
   assign o_blk_last = w_head_last;
`endif

endmodule

// File: tb/tb_buffer_in.sv
`timescale 1ns/1ps
module tb_buffer_in;

   localparam int BW     = 512;
   localparam int DEPTH  = 128;
   localparam int BLK    = 4;
   localparam int CHN    = 4;
   localparam int COLS   = 800 * 8 * CHN / BW;
   localparam int ROWS   = 800;
   localparam int OW     = BW * BLK;
   localparam int BEATS  = COLS * ROWS;
   localparam int WORDS  = BEATS / BLK;
`ifdef BUFFER_IN_OUT_REG_EN
   localparam int LAT      = 1;
   localparam int BP_STALL = 430;
`else
   localparam int LAT      = 0;
   localparam int BP_STALL = 428;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_done;
   logic [BW-1:0] i_im_data;
   logic          i_im_vld;
   logic          o_im_rdy;
   logic [OW-1:0] o_im_data;
   logic          o_im_vld;
   logic          i_im_rdy;
   logic          o_im_in_last;
   logic          o_blk_last;

   buffer_in #(
      .BAND_WIDTH (BW),
      .FIFO_DEPTH (DEPTH),
      .BLK_WIDTH  (BLK),
      .IM_CHN_CNT (CHN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_done       (i_done),
      .i_im_data    (i_im_data),
      .i_im_vld     (i_im_vld),
      .o_im_rdy     (o_im_rdy),
      .o_im_data    (o_im_data),
      .o_im_vld     (o_im_vld),
      .i_im_rdy     (i_im_rdy),
      .o_im_in_last (o_im_in_last),
      .o_blk_last   (o_blk_last)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model state ----------------
   int            n_checks = 0;
   int            n_pass   = 0;
   int            in_idx, out_idx, salt;
   int            lane_occ [BLK];
   logic [OW-1:0] exp_q [$];
   int            acc_cnt = 0;
   int            word_cnt = 0;
   int            in_last_cnt = 0;
   logic          last_vld, last_rdy, last_blk, last_inlast, last_in_x, last_out_x;
   logic [OW-1:0] last_data;

   // Beat content encodes frame salt, row, column and slot so any misrouting is visible.
   function automatic logic [BW-1:0] beat_val(input int s, input int r, input int c);
      logic [BW-1:0] v;
      logic [7:0]    s8;
      logic [9:0]    r10;
      logic [5:0]    c6;
      logic [3:0]    i4;
      s8  = s[7:0];
      r10 = r[9:0];
      c6  = c[5:0];
      for (int i = 0; i < BW / 32; i++) begin
         i4 = i[3:0];
         v[i*32 +: 32] = {s8, r10, c6, i4, 4'h5};
      end
      return v;
   endfunction

   // Word for block-row br, column c: lane j carries row br*BLK+j.
   function automatic logic [OW-1:0] word_for(input int s, input int br, input int c);
      logic [OW-1:0] w;
      for (int j = 0; j < BLK; j++) w[j*BW +: BW] = beat_val(s, br * BLK + j, c);
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_word(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      bit shown;
      n_checks++;
      shown = 1'b0;
      if (act === exp) n_pass++;
      else begin
         for (int j = 0; j < BLK; j++) begin
            if (!shown && act[j*BW +: BW] !== exp[j*BW +: BW]) begin
               $display("FAIL %s lane %0d: got %h expected %h", name, j, act[j*BW +: BW], exp[j*BW +: BW]);
               shown = 1'b1;
            end
         end
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      for (int j = 0; j < BLK; j++) lane_occ[j] = 0;
      in_idx  = 0;
      out_idx = 0;
      salt    = $urandom_range(0, 255);
   endtask

   // ---------------- driver + scoreboard: one clock cycle ----------------
   task automatic cycle(input bit vld, input bit rdy, input bit done, input bit rs);
      int  r, c;
      bit  clr, in_x, out_x;
      @(negedge clk);
      r = (in_idx / COLS) % ROWS;
      c = in_idx % COLS;
      i_im_data = beat_val(salt, r, c);
      i_im_vld  = vld;
      i_im_rdy  = rdy;
      i_done    = done;
      rst       = rs;
      #1;
      clr   = done || rs;
      in_x  = vld && (o_im_rdy === 1'b1);
      out_x = (o_im_vld === 1'b1) && rdy;
      last_vld = o_im_vld; last_rdy = o_im_rdy; last_blk = o_blk_last;
      last_inlast = o_im_in_last; last_data = o_im_data;
      last_in_x = in_x; last_out_x = out_x;
`ifndef BUFFER_IN_OUT_REG_EN
      check("o_im_vld", o_im_vld, exp_q.size() > 0);
      check("o_im_rdy", o_im_rdy, lane_occ[r % BLK] < DEPTH);
`endif
      if (exp_q.size() == 0) check("vld_without_word", o_im_vld, 0);
      check("o_im_in_last", o_im_in_last, in_x && !clr && in_idx == BEATS - 1);
      check("o_blk_last", o_blk_last, (o_im_vld === 1'b1) && (out_idx % WORDS) == WORDS - 1);
      if (o_im_in_last === 1'b1) in_last_cnt++;
      if (clr) begin
         model_clear();
      end else begin
         if (out_x && exp_q.size() > 0) begin
            check_word("out_word", o_im_data, exp_q.pop_front());
            out_idx = (out_idx + 1) % WORDS;
            word_cnt++;
            for (int j = 0; j < BLK; j++) lane_occ[j]--;
         end
         if (in_x) begin
            lane_occ[r % BLK]++;
            if (r % BLK == BLK - 1) exp_q.push_back(word_for(salt, r / BLK, c));
            in_idx = (in_idx + 1) % BEATS;
            acc_cnt++;
         end
      end
   endtask

   // mode: 0 never, 1 always, 2 random
   task automatic run(input int n, input int vmode, input int rmode);
      bit v, q;
      for (int t = 0; t < n; t++) begin
         v = (vmode == 1) || (vmode == 2 && $urandom_range(0, 3) != 0);
         q = (rmode == 1) || (rmode == 2 && $urandom_range(0, 3) != 0);
         cycle(v, q, 1'b0, 1'b0);
      end
   endtask

   typedef struct {
      int   cyc;
      logic vld;
   } vec_t;

   // ---------------- test sequence ----------------
   initial begin
      vec_t tbl [6];
      int   first_vld, vld_run, start, fstart, budget;
      logic [OW-1:0] w0;

      rst = 1'b1; i_done = 1'b0; i_im_vld = 1'b0; i_im_rdy = 1'b0; i_im_data = '0;
      model_clear();
      repeat (3) @(posedge clk);

      // reset state
      cycle(0, 0, 0, 0);
      check("rst_vld", last_vld, 0);
      check("rst_rdy", last_rdy, 1);
      check("rst_blk_last", last_blk, 0);
      check("rst_in_last", last_inlast, 0);

      // ordered fill of rows 0..3 at full rate
      tbl[0] = '{0, 1'b0};
      tbl[1] = '{149, 1'b0};
      tbl[2] = '{150 + LAT, 1'b0};
      tbl[3] = '{151 + LAT, 1'b1};
      tbl[4] = '{200 + LAT, 1'b1};
      tbl[5] = '{201 + LAT, 1'b0};
      w0 = {beat_val(salt, 3, 0), beat_val(salt, 2, 0), beat_val(salt, 1, 0), beat_val(salt, 0, 0)};
      first_vld = -1;
      vld_run = 0;
      for (int t = 0; t < 210; t++) begin
         cycle(t < 200, 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 6; i++)
            if (tbl[i].cyc == t) check($sformatf("fill_vld_t%0d", t), last_vld, tbl[i].vld);
         if (last_vld === 1'b1) begin
            vld_run++;
            if (first_vld < 0) first_vld = t;
         end
         if (t == 151 + LAT) check_word("fill_word0", last_data, w0);
      end
      check("fill_first_vld", first_vld, 151 + LAT);
      check("fill_words_streamed", vld_run, 50);

      // back-pressure: fresh frame, downstream stalled
      cycle(0, 1, 1, 0);
      start = acc_cnt;
      run(600, 1, 0);
      check("bp_stall_beats", acc_cnt - start, BP_STALL);
      check("bp_rdy_low", last_rdy, 0);
      run(800, 1, 1);
      check("bp_resumed", acc_cnt - start > BP_STALL, 1);
      run(200, 0, 1);
      check("bp_drain_empty", exp_q.size(), 0);

      // full frame with random valid/ready
      cycle(0, 1, 1, 0);
      start = acc_cnt;
      fstart = word_cnt;
      in_last_cnt = 0;
      budget = 0;
      while (acc_cnt - start < BEATS && budget < 70000) begin
         run(1, 2, 2);
         budget++;
      end
      check("frame_beats", acc_cnt - start, BEATS);
      run(400, 0, 1);
      check("frame_words", word_cnt - fstart, WORDS);
      check("frame_in_last_pulses", in_last_cnt, 1);
      check("frame_drain_empty", exp_q.size(), 0);

      // i_done mid-frame at row 5 col 10
      budget = 0;
      while (in_idx != 5 * COLS + 10 && budget < 2000) begin
         run(1, 1, 1);
         budget++;
      end
      check("done_reach_pos", in_idx, 5 * COLS + 10);
      cycle(1, 1, 1, 0);
      cycle(0, 1, 0, 0);
      check("done_vld", last_vld, 0);
      check("done_rdy", last_rdy, 1);
      check("done_blk_last", last_blk, 0);
      fstart = word_cnt;
      run(700, 2, 2);
      run(300, 0, 1);
      check("done_fresh_words", word_cnt - fstart > 0, 1);
      check("done_drain_empty", exp_q.size(), 0);

      // rst during simultaneous input and output transfer
      cycle(0, 1, 1, 0);
      run(160, 1, 1);
      cycle(1, 1, 0, 1);
      check("rst_both_xfer", last_in_x && last_out_x, 1);
      cycle(0, 0, 0, 0);
      check("rst2_vld", last_vld, 0);
      check("rst2_rdy", last_rdy, 1);
      check("rst2_blk_last", last_blk, 0);
      check("rst2_in_last", last_inlast, 0);
      run(400, 1, 2);
      run(200, 0, 1);
      check("rst2_drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
